dma_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-side DMA port among NUM_REQ DMA masters, such as the matrix multiplier and a second accelerator or a CPU-side copy engine.
- Each requester uses the matrix block's DMA handshake: req held with stable addr/we/data until a one-cycle ack.
- Transactions are single-word and non-overlapping.
- A watchdog aborts stalled memory accesses and reports an error.

---
 rtl/dma_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dma_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one single-word memory port among NUM_REQ DMA masters.
// A watchdog aborts memory accesses that are never acknowledged.
module dma_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic                        err_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic [$clog2(NUM_REQ)-1:0]  grant_o,
  output logic                        busy_o,
  output logic                        timeout_flag,
  input  logic                        clear_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_n;

  logic [NUM_REQ-1:0] ack_n;
  logic               err_n;
  logic [DATA_W-1:0]  rdata_n;
  logic               mem_req_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic               mem_we_n;
  logic [DATA_W-1:0]  mem_wdata_n;
  logic [GW-1:0]      grant_n;
  logic               flag_n;
  logic [GW-1:0]      last, last_n;
  logic [CW-1:0]      cnt, cnt_n;

  logic               found;
  logic [GW-1:0]      sel;
  logic [GW:0]        t;
  logic [GW-1:0]      j;
  logic               to_hit;

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    t     = '0;
    j     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      t = {1'b0, last} + (GW+1)'(i);
      if (t >= (GW+1)'(NUM_REQ))
        t = t - (GW+1)'(NUM_REQ);
      j = t[GW-1:0];
      if (!found && req_i[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
  end

  // A coincident mem_ack beats the watchdog.
  assign to_hit = (state == BUSY) && !mem_ack &&
                  (cnt == CW'(TIMEOUT-1));

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ack_o        <= '0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      grant_o      <= '0;
      timeout_flag <= 1'b0;
      last         <= GW'(NUM_REQ-1);
      cnt          <= '0;
    end else begin
      state        <= state_n;
      ack_o        <= ack_n;
      err_o        <= err_n;
      rdata_o      <= rdata_n;
      mem_req      <= mem_req_n;
      mem_addr     <= mem_addr_n;
      mem_we       <= mem_we_n;
      mem_wdata    <= mem_wdata_n;
      grant_o      <= grant_n;
      timeout_flag <= flag_n;
      last         <= last_n;
      cnt          <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (found) state_n = BUSY;
      BUSY: if (mem_ack || to_hit) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_n       = '0;
    err_n       = 1'b0;
    rdata_n     = rdata_o;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    mem_we_n    = mem_we;
    mem_wdata_n = mem_wdata;
    grant_n     = grant_o;
    flag_n      = timeout_flag & ~clear_err;
    last_n      = last;
    cnt_n       = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          mem_req_n   = 1'b1;
          mem_addr_n  = addr_i[sel*ADDR_W +: ADDR_W];
          mem_we_n    = we_i[sel];
          mem_wdata_n = wdata_i[sel*DATA_W +: DATA_W];
          grant_n     = sel;
          last_n      = sel;
          cnt_n       = '0;
        end
      end
      BUSY: begin
        cnt_n = cnt + 1'b1;
        if (mem_ack) begin
          rdata_n         = mem_we ? '0 : mem_rdata;
          mem_req_n       = 1'b0;
          ack_n[grant_o]  = 1'b1;
        end else if (to_hit) begin
          rdata_n         = '0;
          mem_req_n       = 1'b0;
          ack_n[grant_o]  = 1'b1;
          err_n           = 1'b1;
          flag_n          = 1'b1;
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: vector table of single transactions
// plus hand-written round-robin, watchdog and reset sequences.
module tb_dma_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR-1:0]     we_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     ack_o;
  logic              err_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;
  logic [0:0]        grant_o;
  logic              busy_o;
  logic              timeout_flag;
  logic              clear_err;

  int n_chk  = 0;
  int n_fail = 0;

  dma_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_flag(timeout_flag), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrd;
    logic [1:0]  ack;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(vec_t v);
    logic got;
    req_i = '0;
    req_i[v.k] = 1'b1;
    addr_i[v.k*AW +: AW] = v.addr;
    we_i[v.k] = v.we;
    wdata_i[v.k*DW +: DW] = v.wdata;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = mem_req;
    end
    chk("mem_req_up", 64'(got), 64'd1);
    if (!got) begin
      req_i = '0;
      return;
    end
    chk("mem_addr", 64'(mem_addr), 64'(v.addr));
    chk("mem_we", 64'(mem_we), 64'(v.we));
    if (v.we) chk("mem_wdata", 64'(mem_wdata), 64'(v.wdata));
    chk("grant", 64'(grant_o), 64'(v.k));
    chk("busy", 64'(busy_o), 64'd1);
    repeat (v.lat) step();
    chk("no_early_ack", 64'(ack_o), 64'd0);
    mem_ack = 1'b1;
    mem_rdata = v.mrd;
    step();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("ack", 64'(ack_o), 64'(v.ack));
    chk("rdata", 64'(rdata_o), 64'(v.rd));
    chk("err", 64'(err_o), 64'd0);
    chk("mem_req_dn", 64'(mem_req), 64'd0);
    req_i = '0;
    step();
    chk("ack_clr", 64'(ack_o), 64'd0);
    step();
    chk("idle_req", 64'(mem_req), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic        prev;
    logic        got;
    int          wc, ng, na, k;
    int          cntk [2];
    logic [31:0] a0, a1, ea;
    vec_t        v;

    tbl[0] = '{0, 32'h1000, 1'b0, 32'h0,    3,  32'h7,    2'b01, 32'h7};
    tbl[1] = '{1, 32'h3000, 1'b1, 32'h2E,   2,  32'h55,   2'b10, 32'h0};
    tbl[2] = '{0, 32'h1010, 1'b1, 32'hDEAD, 0,  32'h99,   2'b01, 32'h0};
    tbl[3] = '{1, 32'h3004, 1'b0, 32'h0,    14, 32'hCAFE, 2'b10, 32'hCAFE};
    tbl[4] = '{0, 32'h1020, 1'b0, 32'h0,    TO-1, 32'h1234, 2'b01, 32'h1234};

    req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0;
    mem_rdata = '0; mem_ack = 1'b0; clear_err = 1'b0;
    do_reset();

    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_flag", 64'(timeout_flag), 64'd0);

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);
    chk("edge_flag", 64'(timeout_flag), 64'd0);

    // Watchdog: requester 1 read, memory never answers.
    req_i = 2'b10;
    addr_i[AW +: AW] = 32'h3100;
    we_i = '0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = mem_req;
    end
    chk("to_req_up", 64'(got), 64'd1);
    wc = 0;
    for (int i = 1; i < TO; i++) begin
      step();
      if (ack_o != 0) wc++;
    end
    chk("to_req_held", 64'(mem_req), 64'd1);
    chk("to_no_ack", 64'(wc), 64'd0);
    step();
    chk("to_ack", 64'(ack_o), 64'b10);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_rdata", 64'(rdata_o), 64'd0);
    chk("to_mem_req", 64'(mem_req), 64'd0);
    chk("to_flag", 64'(timeout_flag), 64'd1);
    req_i = '0;
    step();
    chk("to_err_clr", 64'(err_o), 64'd0);
    step();
    chk("to_flag_sticky", 64'(timeout_flag), 64'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("to_flag_clr", 64'(timeout_flag), 64'd0);
    v = '{1, 32'h3200, 1'b0, 32'h0, 1, 32'hBEEF, 2'b10, 32'hBEEF};
    run_txn(v);

    // Both requesters streaming from reset.
    do_reset();
    a0 = 32'h1000; a1 = 32'h2000;
    addr_i = {a1, a0};
    we_i = '0;
    req_i = 2'b11;
    prev = 1'b0; wc = 0; ng = 0; na = 0;
    cntk[0] = 0; cntk[1] = 0;
    for (int c = 0; c < 400 && na < 12; c++) begin
      step();
      mem_ack = 1'b0;
      if (mem_req && !prev) begin
        ea = ((ng % 2) == 1 ? 32'h2000 : 32'h1000) + 32'(4 * (ng / 2));
        chk("rr_grant", 64'(grant_o), 64'(ng % 2));
        chk("rr_addr", 64'(mem_addr), 64'(ea));
        ng++;
        wc = 0;
      end
      if (mem_req) begin
        wc++;
        if (wc == 2) begin
          mem_ack = 1'b1;
          mem_rdata = 32'h100 + 32'(ng);
        end
      end
      if (ack_o != 0) begin
        chk("rr_onehot", 64'(ack_o == 2'b01 || ack_o == 2'b10), 64'd1);
        chk("rr_ack_req", 64'(mem_req), 64'd0);
        na++;
        k = ack_o[1] ? 1 : 0;
        cntk[k]++;
        if (cntk[k] == 6) req_i[k] = 1'b0;
        else if (k == 0) a0 = a0 + 4;
        else a1 = a1 + 4;
        addr_i = {a1, a0};
      end
      prev = mem_req;
    end
    mem_ack = 1'b0;
    chk("rr_acks", 64'(na), 64'd12);
    chk("rr_grants", 64'(ng), 64'd12);
    chk("rr_cnt0", 64'(cntk[0]), 64'd6);
    req_i = '0;
    step();
    step();

    // Reset while serving requester 1, then a stray mem_ack.
    req_i = 2'b10;
    addr_i[AW +: AW] = 32'h3300;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = mem_req;
    end
    chk("rs_req_up", 64'(got), 64'd1);
    chk("rs_grant1", 64'(grant_o), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_i = '0;
    chk("rs_mem_req", 64'(mem_req), 64'd0);
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_grant", 64'(grant_o), 64'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD;
    step();
    mem_ack = 1'b0;
    chk("rs_no_ack", 64'(ack_o), 64'd0);
    step();
    chk("rs_no_ack2", 64'(ack_o), 64'd0);
    chk("rs_stray_idle", 64'(busy_o), 64'd0);
    addr_i = {32'h2000, 32'h1000};
    req_i = 2'b11;
    step();
    chk("rs_first_req", 64'(mem_req), 64'd1);
    chk("rs_first_grant", 64'(grant_o), 64'd0);
    chk("rs_first_addr", 64'(mem_addr), 64'h1000);
    req_i = '0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rs_fin_ack", 64'(ack_o), 64'b01);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
